sensor_sequence_gen: RTL and testbench
======================================

Name: sensor_sequence_gen

Overview:
- Drives the two parking-barrier sensor lines `a`/`b` through a legal vehicle-passage sequence on command: entry or exit.
- Sits in front of the debouncer/passage-detection FSM as a self-test stimulus source on the FPGA, replacing the push-buttons.
- Keeps a model occupancy count (0..7) and refuses commands the lot could not physically accept.

Parameters:
- DWELL_W, 16, width of the per-phase dwell input and internal dwell counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset: synchronous, active-low. Sampled on the rising edge of clk; rst=0 resets.
- start  in  1  command strobe, sampled only in IDLE.
- dir  in  1  0 = entry, 1 = exit; sampled with start.
- dwell  in  DWELL_W  cycles per phase; sampled with start; 0 is treated as 1.
- abort  in  1  cancel the sequence in progress.
- a  out  1  emulated sensor A, registered.
- b  out  1  emulated sensor B, registered.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse: sequence completed.
- reject  out  1  one-cycle pulse: command refused.
- exp_count  out  3  model occupancy, 0..7.

Behaviour:
- Reset (rst=0 at clk edge): state IDLE, a=b=0, busy=0, done=0, reject=0, exp_count=0, dwell counter=0. Reset mid-sequence aborts immediately; no done pulse.
- States: IDLE, PH1, PH2, PH3, GAP. Outputs a, b, busy and the pulses are registered from the state and counter.
- Entry pattern {a,b} across PH1/PH2/PH3/GAP: 10, 11, 01, 00.
- Exit pattern {a,b} across PH1/PH2/PH3/GAP: 01, 11, 10, 00.
- Command acceptance in IDLE, with start=1 and abort=0:
  - dir=0 and exp_count==7 → reject.
  - dir=1 and exp_count==0 → reject.
  - Otherwise accept: latch dir, latch D = max(dwell,1), enter PH1.
- Timing, with start sampled in cycle 0:
  - PH1 outputs visible cycles 1..D.
  - PH2 outputs visible cycles D+1..2D.
  - PH3 outputs visible cycles 2D+1..3D.
  - GAP (a=b=0) visible cycles 3D+1..4D.
  - Cycle 4D+1: done=1, busy=0, exp_count updated (+1 entry / −1 exit), state IDLE.
  - busy=1 exactly in cycles 1..4D.
- Each phase lasts exactly D cycles. The dwell counter is DWELL_W bits, counts 1..D, and never wraps.
- Reject timing: reject=1 in cycle 1 for one cycle; a, b, busy and exp_count unchanged.
- start while busy: ignored, no reject; dir/dwell changes are ignored after latching.
- abort while busy (any of PH1..GAP):
  - Next cycle: a=b=0, busy=0, IDLE.
  - No done, exp_count unchanged.
  - An abort in the same cycle the last GAP cycle completes still wins: no done, no count change.
- abort and start both high in IDLE: abort wins; start is ignored and no reject is issued.
- abort in IDLE with start=0: no effect.
- New command: start is accepted in the same cycle done is high, since the state is already IDLE. That command's PH1 begins the following cycle, and exp_count already reflects the prior completion.
- exp_count saturation: never wraps; the 0/7 bounds are guaranteed by the reject rule.
- done and reject are never high in the same cycle.

Test Plan:
- Entry, D=3, exp_count=0: start(dir=0,dwell=3) in cycle 0 → {a,b}=10 in cycles 1-3, 11 in 4-6, 01 in 7-9, 00 in 10-12. Cycle 13: done=1, busy=0, exp_count=1.
- Exit, D=1, exp_count=1: {a,b}=01,11,10,00 in cycles 1-4 → done in cycle 5, exp_count=0. A further exit command gets reject=1 in cycle 1, a=b=0 throughout, exp_count stays 0.
- Seven back-to-back entries with dwell=2, each start asserted on its predecessor's done cycle → exp_count=7. Eighth entry → reject pulse, no sensor activity. An exit then returns exp_count to 6.
- Entry with dwell=5, abort in cycle 7 (PH2) → cycle 8: a=b=0, busy=0. No done ever fires, exp_count unchanged.
- dwell=0 entry → behaves as D=1, done in cycle 5. start re-pulsed in cycle 2 is ignored, with no reject and unchanged timing.
- Exit sequence with rst=0 during PH3 → next cycle all outputs 0 and exp_count=0.

Source files
------------

// File: rtl/sensor_sequence_gen_if.sv
// Command/status bundle between the sensor sequence generator and its controller.
// The generator itself connects through the slave modport.
interface sensor_sequence_gen_if #(
  parameter int unsigned DWELL_W = 16
);
  logic               start;
  logic               dir;
  logic [DWELL_W-1:0] dwell;
  logic               abort;
  logic               a;
  logic               b;
  logic               busy;
  logic               done;
  logic               reject;
  logic [2:0]         exp_count;

  modport master (
    output start, dir, dwell, abort,
    input  a, b, busy, done, reject, exp_count
  );

  modport slave (
    input  start, dir, dwell, abort,
    output a, b, busy, done, reject, exp_count
  );
endinterface

// File: rtl/sensor_sequence_gen.sv
// Emulates parking-barrier sensors A/B through an entry or exit passage on command,
// tracking a model occupancy count and refusing commands the lot cannot accept.
module sensor_sequence_gen #(
  parameter int unsigned DWELL_W = 16
) (
  input logic                 clk,
  input logic                 rst,
  sensor_sequence_gen_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StPh1, StPh2, StPh3, StGap} state_e;

  state_e             state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               dir_q, dir_d;
  logic [2:0]         count_q, count_d;
  logic               a_q, a_d, b_q, b_d;
  logic               busy_q, busy_d, done_q, done_d, reject_q, reject_d;

  logic refuse, accept, phase_end;

  // Abort takes priority over start in IDLE, so neither accept nor refuse fires.
  assign refuse    = bus.start && !bus.abort && (bus.dir ? (count_q == 3'd0) : (count_q == 3'd7));
  assign accept    = bus.start && !bus.abort && !refuse;
  assign phase_end = (cnt_q == dwell_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      dwell_q  <= '0;
      dir_q    <= 1'b0;
      count_q  <= 3'd0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dwell_q  <= dwell_d;
      dir_q    <= dir_d;
      count_q  <= count_d;
      a_q      <= a_d;
      b_q      <= b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      reject_q <= reject_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    dir_d   = dir_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StPh1;
          cnt_d   = DWELL_W'(1);
          dir_d   = bus.dir;
          dwell_d = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
        end
      end
      default: begin
        if (bus.abort) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (phase_end) begin
          cnt_d = DWELL_W'(1);
          unique case (state_q)
            StPh1:   state_d = StPh2;
            StPh2:   state_d = StPh3;
            StPh3:   state_d = StGap;
            default: begin
              state_d = StIdle;
              cnt_d   = '0;
              count_d = dir_q ? (count_q - 3'd1) : (count_q + 3'd1);
            end
          endcase
        end else begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end
    endcase
  end

  // Outputs are precomputed from the next state so they register alongside it.
  always_comb begin
    a_d      = 1'b0;
    b_d      = 1'b0;
    busy_d   = (state_d != StIdle);
    done_d   = (state_q == StGap) && phase_end && !bus.abort;
    reject_d = (state_q == StIdle) && refuse;
    unique case (state_d)
      StPh1: begin
        a_d = !dir_d;
        b_d = dir_d;
      end
      StPh2: begin
        a_d = 1'b1;
        b_d = 1'b1;
      end
      StPh3: begin
        a_d = dir_d;
        b_d = !dir_d;
      end
      default: ;
    endcase
  end

  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.reject    = reject_q;
  assign bus.exp_count = count_q;

endmodule

// File: tb/tb_sensor_sequence_gen.sv
// Directed bench for sensor_sequence_gen: entry/exit patterns, occupancy bounds,
// abort, reset mid-sequence and start-while-busy behaviour.
module tb_sensor_sequence_gen;

  localparam int unsigned DWELL_W = 16;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  sensor_sequence_gen_if #(.DWELL_W(DWELL_W)) bus ();

  sensor_sequence_gen #(.DWELL_W(DWELL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance into the next cycle; outputs are stable 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {a,b} for cycle cyc (1..4d) of a passage in direction dir.
  function automatic logic [1:0] exp_ab(input logic dir, input int d, input int cyc);
    int ph;
    ph = (cyc - 1) / d;
    case (ph)
      0:       return dir ? 2'b01 : 2'b10;
      1:       return 2'b11;
      2:       return dir ? 2'b10 : 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.a, bus.b, bus.busy, bus.done, bus.reject, bus.exp_count} !== 8'h00) begin
      errors++;
      $display("FAIL reset outs a=%b b=%b busy=%b done=%b reject=%b cnt=%0d required all 0",
               bus.a, bus.b, bus.busy, bus.done, bus.reject, bus.exp_count);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({bus.a, bus.b, bus.busy, bus.done, bus.reject} !== 5'b0) begin
      errors++;
      $display("FAIL reset_release outs=%b required 00000",
               {bus.a, bus.b, bus.busy, bus.done, bus.reject});
    end
  endtask

  task automatic test_entry();
    bus.start = 1'b1; bus.dir = 1'b0; bus.dwell = 16'd3;
    for (int c = 1; c <= 14; c++) begin
      tick();
      bus.start = 1'b0;
      if (c <= 12) begin
        checks++;
        if ({bus.a, bus.b} !== exp_ab(1'b0, 3, c) || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
          errors++;
          $display("FAIL entry_c%0d ab=%b busy=%b done=%b required ab=%b busy=1 done=0",
                   c, {bus.a, bus.b}, bus.busy, bus.done, exp_ab(1'b0, 3, c));
        end
      end else if (c == 13) begin
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.exp_count !== 3'd1 ||
            {bus.a, bus.b} !== 2'b00) begin
          errors++;
          $display("FAIL entry_done done=%b busy=%b cnt=%0d ab=%b required 1 0 1 00",
                   bus.done, bus.busy, bus.exp_count, {bus.a, bus.b});
        end
      end else begin
        checks++;
        if (bus.done !== 1'b0) begin
          errors++;
          $display("FAIL entry_done_pulse done=%b required 0", bus.done);
        end
      end
    end
  endtask

  task automatic test_exit();
    bus.start = 1'b1; bus.dir = 1'b1; bus.dwell = 16'd1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      bus.start = 1'b0;
      if (c <= 4) begin
        checks++;
        if ({bus.a, bus.b} !== exp_ab(1'b1, 1, c) || bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL exit_c%0d ab=%b busy=%b required ab=%b busy=1",
                   c, {bus.a, bus.b}, bus.busy, exp_ab(1'b1, 1, c));
        end
      end else begin
        checks++;
        if (bus.done !== 1'b1 || bus.exp_count !== 3'd0) begin
          errors++;
          $display("FAIL exit_done done=%b cnt=%0d required 1 0", bus.done, bus.exp_count);
        end
      end
    end
    // Lot now empty: a further exit must be refused.
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.reject !== 1'b1 || {bus.a, bus.b, bus.busy} !== 3'b000 || bus.exp_count !== 3'd0) begin
      errors++;
      $display("FAIL exit_reject reject=%b ab=%b busy=%b cnt=%0d required 1 00 0 0",
               bus.reject, {bus.a, bus.b}, bus.busy, bus.exp_count);
    end
    tick();
    checks++;
    if (bus.reject !== 1'b0 || {bus.a, bus.b, bus.busy} !== 3'b000) begin
      errors++;
      $display("FAIL exit_reject_pulse reject=%b ab=%b busy=%b required 0 00 0",
               bus.reject, {bus.a, bus.b}, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    bus.start = 1'b1; bus.dir = 1'b0; bus.dwell = 16'd2;
    for (int k = 0; k < 7; k++) begin
      for (int c = 1; c <= 9; c++) begin
        tick();
        if (c == 1) begin
          bus.start = 1'b0;
          checks++;
          if ({bus.a, bus.b} !== 2'b10 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_%0d_ph1 ab=%b busy=%b required 10 1", k, {bus.a, bus.b}, bus.busy);
          end
        end else if (c == 9) begin
          checks++;
          if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.reject !== 1'b0 ||
              bus.exp_count !== 3'(k + 1)) begin
            errors++;
            $display("FAIL b2b_%0d_done done=%b busy=%b reject=%b cnt=%0d required 1 0 0 %0d",
                     k, bus.done, bus.busy, bus.reject, bus.exp_count, k + 1);
          end
          if (k < 6) bus.start = 1'b1;
        end
      end
    end
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.reject !== 1'b1 || {bus.a, bus.b, bus.busy} !== 3'b000 || bus.exp_count !== 3'd7) begin
      errors++;
      $display("FAIL full_reject reject=%b ab=%b busy=%b cnt=%0d required 1 00 0 7",
               bus.reject, {bus.a, bus.b}, bus.busy, bus.exp_count);
    end
    tick();
    checks++;
    if (bus.reject !== 1'b0 || {bus.a, bus.b, bus.busy} !== 3'b000) begin
      errors++;
      $display("FAIL full_reject_quiet reject=%b ab=%b busy=%b required 0 00 0",
               bus.reject, {bus.a, bus.b}, bus.busy);
    end
    bus.start = 1'b1; bus.dir = 1'b1; bus.dwell = 16'd1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      bus.start = 1'b0;
    end
    checks++;
    if (bus.done !== 1'b1 || bus.exp_count !== 3'd6) begin
      errors++;
      $display("FAIL full_exit done=%b cnt=%0d required 1 6", bus.done, bus.exp_count);
    end
  endtask

  task automatic test_abort();
    logic saw_done;
    tick();
    bus.start = 1'b1; bus.dir = 1'b0; bus.dwell = 16'd5;
    for (int c = 1; c <= 7; c++) begin
      tick();
      bus.start = 1'b0;
    end
    checks++;
    if ({bus.a, bus.b} !== 2'b11 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre ab=%b busy=%b required 11 1", {bus.a, bus.b}, bus.busy);
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checks++;
    if ({bus.a, bus.b, bus.busy} !== 3'b000) begin
      errors++;
      $display("FAIL abort_next ab=%b busy=%b required 00 0", {bus.a, bus.b}, bus.busy);
    end
    saw_done = 1'b0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0 || bus.exp_count !== 3'd6) begin
      errors++;
      $display("FAIL abort_after activity=%b cnt=%0d required 0 6", saw_done, bus.exp_count);
    end
  endtask

  task automatic test_dwell_zero();
    bus.start = 1'b1; bus.dir = 1'b0; bus.dwell = 16'd0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      bus.start = 1'b0;
      if (c == 2) begin
        bus.start = 1'b1; bus.dir = 1'b1; bus.dwell = 16'd4;
      end
      if (c <= 4) begin
        checks++;
        if ({bus.a, bus.b} !== exp_ab(1'b0, 1, c) || bus.reject !== 1'b0 || bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL dwell0_c%0d ab=%b reject=%b busy=%b required ab=%b 0 1",
                   c, {bus.a, bus.b}, bus.reject, bus.busy, exp_ab(1'b0, 1, c));
        end
      end else begin
        checks++;
        if (bus.done !== 1'b1 || bus.exp_count !== 3'd7) begin
          errors++;
          $display("FAIL dwell0_done done=%b cnt=%0d required 1 7", bus.done, bus.exp_count);
        end
      end
    end
    bus.dir = 1'b0;
  endtask

  task automatic test_abort_start_idle();
    tick();
    bus.start = 1'b1; bus.abort = 1'b1; bus.dir = 1'b1; bus.dwell = 16'd1;
    tick();
    bus.start = 1'b0; bus.abort = 1'b0;
    checks++;
    if (bus.reject !== 1'b0 || bus.busy !== 1'b0 || {bus.a, bus.b} !== 2'b00) begin
      errors++;
      $display("FAIL abort_start_idle reject=%b busy=%b ab=%b required 0 0 00",
               bus.reject, bus.busy, {bus.a, bus.b});
    end
  endtask

  task automatic test_abort_last_gap();
    bus.start = 1'b1; bus.dir = 1'b1; bus.dwell = 16'd1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      bus.start = 1'b0;
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.exp_count !== 3'd7) begin
      errors++;
      $display("FAIL abort_gap done=%b busy=%b cnt=%0d required 0 0 7",
               bus.done, bus.busy, bus.exp_count);
    end
  endtask

  task automatic test_reset_mid();
    tick();
    bus.start = 1'b1; bus.dir = 1'b1; bus.dwell = 16'd2;
    for (int c = 1; c <= 5; c++) begin
      tick();
      bus.start = 1'b0;
    end
    checks++;
    if ({bus.a, bus.b} !== 2'b10 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_ph3 ab=%b busy=%b required 10 1", {bus.a, bus.b}, bus.busy);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++;
    if ({bus.a, bus.b, bus.busy, bus.done, bus.reject, bus.exp_count} !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_outs ab=%b busy=%b done=%b reject=%b cnt=%0d required all 0",
               {bus.a, bus.b}, bus.busy, bus.done, bus.reject, bus.exp_count);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_after done=%b busy=%b required 0 0", bus.done, bus.busy);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.dir = 1'b0;
    bus.dwell = '0;
    bus.abort = 1'b0;
    test_reset();
    test_entry();
    test_exit();
    test_back_to_back();
    test_abort();
    test_dwell_zero();
    test_abort_start_idle();
    test_abort_last_gap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
